// File: rtl/lfsr_prbs_serializer_if.sv
// lfsr_prbs_serializer_if: control inputs and serial-lane outputs of the PRBS serializer
interface lfsr_prbs_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] seed;
  logic load, enable, start;
  logic out, valid, done, busy;
  logic [WIDTH-1:0] state;
  modport master(output seed, load, enable, start, input out, valid, done, busy, state);
  modport slave(input seed, load, enable, start, output out, valid, done, busy, state);
endinterface

// File: rtl/lfsr_prbs_serializer.sv
// lfsr_prbs_serializer: Galois PRBS with zero-state insertion and a snapshot serializer
// LFSR_MSB_FIRST_EN: when defined the snapshot is shifted out MSB first instead of LSB first
module lfsr_prbs_serializer #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(8'b10101010)
) (
  input logic clk,
  input logic rst,
  lfsr_prbs_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, SHIFT} st_e;
  st_e st_q, st_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, shadow_q, shadow_d, step;
  logic [CW-1:0] cnt_q, cnt_d;
  logic out_q, out_d, valid_q, valid_d, done_q, done_d, busy_q, busy_d;
  logic fb, last;
  // the all-zero term splices state 0 into the cycle so it is never a lock-up
  assign fb = lfsr_q[WIDTH-1] ^ ~|lfsr_q[WIDTH-2:0];
  assign step = {lfsr_q[WIDTH-2:0], fb} ^ ({TAPS[WIDTH-1:1], 1'b0} & {WIDTH{fb}});
  assign last = cnt_q == CW'(WIDTH - 1);
  always_comb lfsr_d = bus.load ? bus.seed : bus.enable ? step : lfsr_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) st_q <= IDLE;
    else st_q <= st_d;
  always_comb begin
    st_d = st_q;
    if (st_q == IDLE && bus.start) st_d = SHIFT;
    else if (st_q == SHIFT && last) st_d = IDLE;
  end
  // snapshot takes the pre-load, pre-step LFSR value; outputs are registered one cycle after the FSM
  always_comb begin
    shadow_d = shadow_q;
    cnt_d = cnt_q;
    out_d = 1'b0;
    valid_d = 1'b0;
    done_d = 1'b0;
    busy_d = st_q == SHIFT;
    if (st_q == IDLE) begin
      if (bus.start) begin
        shadow_d = lfsr_q;
        cnt_d = '0;
      end
    end else begin
`ifdef LFSR_MSB_FIRST_EN
      out_d = shadow_q[WIDTH-1];
      shadow_d = shadow_q << 1;
`else
      out_d = shadow_q[0];
      shadow_d = shadow_q >> 1;
`endif
      valid_d = 1'b1;
      done_d = last;
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      lfsr_q <= bus.seed;
      shadow_q <= '0;
      cnt_q <= '0;
      out_q <= 1'b0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      shadow_q <= shadow_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      valid_q <= valid_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  assign bus.out = out_q;
  assign bus.valid = valid_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.state = lfsr_q;
endmodule

// File: tb/tb_lfsr_prbs_serializer.sv
// tb_lfsr_prbs_serializer: vector table for LFSR stepping plus a serial-bit scoreboard
module tb_lfsr_prbs_serializer;
  localparam int W = 8;
  localparam logic [W-1:0] TAPS = 8'b10101010;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  lfsr_prbs_serializer_if #(.WIDTH(W)) bus();
  lfsr_prbs_serializer #(.WIDTH(W), .TAPS(TAPS)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed { logic bit_v; logic last; } exp_t;
  typedef struct { bit by_rst; bit ld_en; logic [W-1:0] seed; int n; logic [W-1:0] exp; } vec_t;
  exp_t sbq[$];
  logic [W-1:0] m;
  function automatic logic [W-1:0] step(input logic [W-1:0] s);
    logic f;
    logic [W-1:0] n;
    f = s[W-1] ^ (s[W-2:0] == '0);
    n[0] = f;
    for (int i = 1; i < W; i++) n[i] = s[i-1] ^ (TAPS[i] & f);
    return n;
  endfunction
  always @(posedge clk or negedge rst)
    if (!rst) m <= bus.seed;
    else if (bus.load) m <= bus.seed;
    else if (bus.enable) m <= step(m);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      if (bus.valid) begin
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: got valid=1 expected no pending bit at %0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("serial_out", 32'(bus.out), 32'(e.bit_v));
          chk("serial_done", 32'(bus.done), 32'(e.last));
          chk("serial_busy", 32'(bus.busy), 1);
        end
      end else chk("idle_outs", 32'({bus.out, bus.done, bus.busy}), 0);
    end
  end
  task automatic push(input logic [W-1:0] s);
    for (int i = 0; i < W; i++)
`ifdef LFSR_MSB_FIRST_EN
      sbq.push_back('{s[W-1-i], i == W-1});
`else
      sbq.push_back('{s[i], i == W-1});
`endif
  endtask
  task automatic do_reset(input logic [W-1:0] s);
    bus.seed = s;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask
  task automatic do_load(input logic [W-1:0] s);
    bus.seed = s;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask
  task automatic steps(input int n);
    bus.enable = 1'b1;
    repeat (n) @(negedge clk);
    bus.enable = 1'b0;
  endtask
  task automatic burst(input bit en);
    push(m);
    bus.start = 1'b1;
    bus.enable = en;
    @(negedge clk);
    bus.start = 1'b0;
    chk("first_bit_latency", 32'(bus.valid), 0);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      chk("valid_window", 32'(bus.valid), 1);
    end
    chk("done_at_width", 32'(bus.done), 1);
  endtask
  vec_t vt[7];
  int p, first_ret, got;
  logic [W-1:0] s;
  bit seen[logic [W-1:0]];
  initial begin
    bus.seed = '0;
    bus.load = 1'b0;
    bus.enable = 1'b0;
    bus.start = 1'b0;
    vt[0] = '{1'b1, 1'b0, 8'h81, 1, 8'hA9};
    vt[1] = '{1'b1, 1'b0, 8'h01, 1, 8'h02};
    vt[2] = '{1'b0, 1'b0, 8'h80, 1, 8'h00};
    vt[3] = '{1'b0, 1'b0, 8'h80, 2, 8'hAB};
    vt[4] = '{1'b0, 1'b0, 8'h00, 1, 8'hAB};
    vt[5] = '{1'b0, 1'b1, 8'h3C, 0, 8'h3C};
    vt[6] = '{1'b0, 1'b0, 8'h01, 3, 8'h08};
    @(negedge clk);
    foreach (vt[i]) begin
      if (vt[i].by_rst) begin
        do_reset(vt[i].seed);
        chk("reset_outs", 32'({bus.out, bus.valid, bus.done, bus.busy}), 0);
      end else if (vt[i].ld_en) begin
        bus.seed = vt[i].seed;
        bus.load = 1'b1;
        bus.enable = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        bus.enable = 1'b0;
      end else do_load(vt[i].seed);
      chk("seed_state", 32'(bus.state), 32'(vt[i].seed));
      if (vt[i].n > 0) steps(vt[i].n);
      chk("step_state", 32'(bus.state), 32'(vt[i].exp));
    end
    do_load(8'h01);
    s = 8'h01;
    p = 0;
    do begin
      s = step(s);
      p++;
    end while (s != 8'h01 && p < 300);
    $display("[TB] info: model period from 0x01 is %0d steps", p);
    first_ret = 0;
    bus.enable = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      seen[bus.state] = 1'b1;
      if (bus.state == 8'h01 && first_ret == 0) first_ret = k;
    end
    bus.enable = 1'b0;
    chk("period_return", 32'(first_ret), 32'(p));
    chk("period_distinct", 32'(seen.num()), 32'(p));
    chk("period_trace", 32'(bus.state), 32'(m));
    do_load(8'hC1);
    chk("ser_seed", 32'(bus.state), 32'hC1);
    burst(1'b0);
    @(negedge clk);
    chk("valid_fall", 32'(bus.valid), 0);
    chk("drained_single", 32'(sbq.size()), 0);
    do_load(8'h96);
    burst(1'b0);
    burst(1'b1);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("valid_fall_b2b", 32'(bus.valid), 0);
    chk("drained_b2b", 32'(sbq.size()), 0);
    do_load(8'h3C);
    push(m);
    bus.start = 1'b1;
    bus.enable = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.seed = 8'h55;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("load_mid_burst", 32'(bus.state), 32'h55);
    chk("busy_mid_burst", 32'(bus.busy), 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (W) @(negedge clk);
    bus.enable = 1'b0;
    chk("drained_concurrent", 32'(sbq.size()), 0);
    chk("no_requeue", 32'(bus.busy), 0);
    chk("state_after_steps", 32'(bus.state), 32'(m));
    do_reset(8'h5A);
    push(m);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && got < 3; k++) begin
      @(negedge clk);
      if (bus.valid) got++;
    end
    chk("three_bits_seen", 32'(got), 3);
    #2;
    bus.seed = 8'hE7;
    rst = 1'b0;
    #1;
    chk("abort_outs", 32'({bus.out, bus.valid, bus.done, bus.busy}), 0);
    chk("abort_state", 32'(bus.state), 32'hE7);
    sbq.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_abort_state", 32'(bus.state), 32'hE7);
    burst(1'b0);
    @(negedge clk);
    chk("drained_after_abort", 32'(sbq.size()), 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
